// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: execute/write-back stage for a small register file.
// Drives the two read addresses, captures both operands, computes one ALU
// operation (MUL is a multi-cycle shift-add) and writes the result back.
// Optional feature macro: FLAGS_EN adds zero (zf) and carry (cf) flag outputs.
module exec_writeback_unit #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] crs,
    input  logic [DATA_W-1:0] crt,
    output logic [DATA_W-1:0] dw,
    output logic [ADDR_W-1:0] rw,
    output logic              rwe,
    output logic              busy,
`ifdef FLAGS_EN
    output logic              zf,
    output logic              cf,
`endif
    output logic              done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                exec_last;

    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;

    logic [2*DATA_W-1:0] mul_acc;
    logic [2*DATA_W-1:0] mul_mcand;
    logic [2*DATA_W-1:0] mul_step;
    logic [DATA_W-1:0]   mul_mplier;
    logic [CNT_W-1:0]    mul_cnt;

    logic [DATA_W:0]     alu_out;
    logic [DATA_W-1:0]   result;
    logic                res_carry;

    // MUL stays in EXEC until every multiplier bit has been consumed
    always_comb begin
        exec_last = (op_q != OP_MUL) || (mul_cnt == MUL_LAST);
    end

    // Next-state logic; an instruction is only taken while idle and advertising ready
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ:    state_next = EXEC;
            EXEC:    if (exec_last) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Single-cycle ALU; bit DATA_W carries the ADD carry-out or SUB borrow
    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:  alu_out = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_out = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_out = {1'b0, op_a & op_b};
            OP_OR:   alu_out = {1'b0, op_a | op_b};
            OP_XOR:  alu_out = {1'b0, op_a ^ op_b};
            OP_SHL:  alu_out = {1'b0, op_a << op_b[1:0]};
            default: alu_out = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            rs         <= '0;
            rt         <= '0;
            rw         <= '0;
            dw         <= '0;
            rwe        <= 1'b0;
            done       <= 1'b0;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            result     <= '0;
            res_carry  <= 1'b0;
        end else begin
            in_ready <= (state == IDLE) && !accept;
            busy     <= (state_next != IDLE);
            rwe      <= (state == WB) && (op_q != OP_NOP);
            done     <= (state == WB);

            if (accept) begin
                op_q <= in_op;
                rd_q <= in_rd;
                rs   <= in_rs;
                rt   <= in_rt;
            end

            if (state == READ) begin
                op_a       <= crs;
                op_b       <= crt;
                mul_acc    <= '0;
                mul_mcand  <= {{DATA_W{1'b0}}, crs};
                mul_mplier <= crt;
                mul_cnt    <= '0;
            end

            if (state == EXEC) begin
                if (op_q == OP_MUL) begin
                    mul_acc    <= mul_step;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 1'b1;
                    if (exec_last) begin
                        result    <= mul_step[DATA_W-1:0];
                        res_carry <= |mul_step[2*DATA_W-1:DATA_W];
                    end
                end else begin
                    result    <= alu_out[DATA_W-1:0];
                    res_carry <= alu_out[DATA_W];
                end
            end

            if ((state == WB) && (op_q != OP_NOP)) begin
                dw <= result;
                rw <= rd_q;
            end
        end
    end

`ifdef FLAGS_EN
    // Flags follow each written result; NOP leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if ((state == WB) && (op_q != OP_NOP)) begin
            zf <= (result == '0);
            cf <= res_carry;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = res_carry;
`endif

endmodule

// File: tb/tb_exec_writeback_unit.sv
// tb_exec_writeback_unit: directed and randomized checks of exec_writeback_unit
// against an arithmetic reference model, with a behavioural register file.
`timescale 1ns/1ps
module tb_exec_writeback_unit;

    localparam int DW   = 4;
    localparam int AW   = 2;
    localparam int NREG = 1 << AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic [AW-1:0] rs, rt, rw;
    logic [DW-1:0] crs, crt, dw;
    logic          rwe, busy, done;
`ifdef FLAGS_EN
    logic          zf, cf;
`endif

    logic [DW-1:0] regs [NREG];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] ref_regs [NREG];
    logic [DW-1:0] ref_dw;
    logic [AW-1:0] ref_rw;
    logic          ref_zf, ref_cf;

    int checks;
    int errors;

    exec_writeback_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_rs(in_rs),
        .in_rt(in_rt),
        .in_rd(in_rd),
        .rs(rs),
        .rt(rt),
        .crs(crs),
        .crt(crt),
        .dw(dw),
        .rw(rw),
        .rwe(rwe),
        .busy(busy),
`ifdef FLAGS_EN
        .zf(zf),
        .cf(cf),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, write port shared with a preload path
    always @(posedge clk) begin
        if (rwe) begin
            regs[rw] <= dw;
        end else if (pl_en) begin
            regs[pl_addr] <= pl_data;
        end
    end
    assign crs = regs[rs];
    assign crt = regs[rt];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions
    function automatic void model_exec(input logic [2:0] op, input int a, input int b,
                                       output logic [DW-1:0] res, output logic carry);
        int full;
        int mask;
        mask  = (1 << DW) - 1;
        full  = 0;
        carry = 1'b0;
        case (op)
            3'b000: begin full = a + b; carry = (full > mask); end
            3'b001: begin full = a - b; carry = (a < b); end
            3'b010: full = a & b;
            3'b011: full = a | b;
            3'b100: full = a ^ b;
            3'b101: full = a << (b % 4);
            3'b110: begin full = a * b; carry = (full > mask); end
            default: full = 0;
        endcase
        res = DW'(full & mask);
    endfunction

    task automatic model_commit(input logic [2:0] op, input logic [AW-1:0] s,
                                input logic [AW-1:0] t, input logic [AW-1:0] d);
        logic [DW-1:0] r;
        logic          c;
        if (op != OP_NOP) begin
            model_exec(op, int'(ref_regs[s]), int'(ref_regs[t]), r, c);
            ref_dw      = r;
            ref_rw      = d;
            ref_zf      = (r == '0);
            ref_cf      = c;
            ref_regs[d] = r;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_regs[a] = v;
    endtask

    task automatic check_flags(input string tag);
`ifdef FLAGS_EN
        check_output({tag, "_zf"}, 32'(zf), 32'(ref_zf));
        check_output({tag, "_cf"}, 32'(cf), 32'(ref_cf));
`else
        if (tag.len() == 0) $display("[TB] no flags");
`endif
    endtask

    // Issue one instruction and follow it cycle by cycle through write-back
    task automatic do_instr(input logic [2:0] op, input logic [AW-1:0] s,
                            input logic [AW-1:0] t, input logic [AW-1:0] d);
        int   lat;
        int   guard;
        logic stray;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("ready_to_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = s;
        in_rt    = t;
        in_rd    = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_rs    = 2'($urandom);
        in_rt    = 2'($urandom);
        in_rd    = 2'($urandom);
        check_output("read_rs", 32'(rs), 32'(s));
        check_output("read_rt", 32'(rt), 32'(t));
        check_output("busy_accept", 32'(busy), 32'd1);
        check_output("ready_drop", 32'(in_ready), 32'd0);
        lat   = (op == OP_MUL) ? 2 + DW : 3;
        stray = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            stray = stray | rwe | done;
        end
        check_output("early_pulse", 32'(stray), 32'd0);
        @(posedge clk); #1;
        model_commit(op, s, t, d);
        check_output("wb_done", 32'(done), 32'd1);
        check_output("wb_rwe", 32'(rwe), 32'(op != OP_NOP));
        if (op != OP_NOP) begin
            check_output("wb_rw", 32'(rw), 32'(ref_rw));
            check_output("wb_dw", 32'(dw), 32'(ref_dw));
        end
        check_flags("wb");
        @(posedge clk); #1;
        check_output("post_done", 32'(done), 32'd0);
        check_output("post_rwe", 32'(rwe), 32'd0);
        check_output("ready_return", 32'(in_ready), 32'd1);
        check_output("regfile_dest", 32'(regs[d]), 32'(ref_regs[d]));
    endtask

    // Main directed sequence followed by randomized instructions
    initial begin
        logic stray;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rs    = '0;
        in_rt    = '0;
        in_rd    = '0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        ref_dw   = '0;
        ref_rw   = '0;
        ref_zf   = 1'b0;
        ref_cf   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_rwe", 32'(rwe), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rs", 32'(rs), 32'd0);
        check_output("rst_rt", 32'(rt), 32'd0);
        check_output("rst_rw", 32'(rw), 32'd0);
        check_output("rst_dw", 32'(dw), 32'd0);
        check_flags("rst");

        preload(0, 4'h0);
        preload(1, 4'h3);
        preload(2, 4'h5);
        preload(3, 4'h0);
        check_output("rst_hold_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("release_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_output("release_ready_high", 32'(in_ready), 32'd1);
        check_output("release_busy", 32'(busy), 32'd0);

        $display("[TB] directed ALU operations");
        do_instr(OP_ADD, 1, 2, 3);
        do_instr(OP_SUB, 1, 2, 0);
        do_instr(OP_MUL, 1, 2, 3);

        $display("[TB] back-to-back with in_valid held");
        preload(1, 4'h3);
        check_output("b2b_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_rs    = 1;
        in_rt    = 1;
        in_rd    = 0;
        @(posedge clk); #1;
        in_rs = 0;
        in_rt = 0;
        in_rd = 2;
        stray = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            stray = stray | in_ready;
        end
        check_output("b2b_ignored", 32'(stray), 32'd0);
        @(posedge clk); #1;
        model_commit(OP_ADD, 1, 1, 0);
        check_output("b2b_first_done", 32'(done), 32'd1);
        check_output("b2b_first_dw", 32'(dw), 32'(ref_dw));
        check_output("b2b_first_rw", 32'(rw), 32'd0);
        check_output("b2b_rs_hold", 32'(rs), 32'd1);
        check_output("b2b_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_output("b2b_ready_back", 32'(in_ready), 32'd1);
        check_output("b2b_idle", 32'(busy), 32'd0);
        check_output("b2b_r0", 32'(regs[0]), 32'(ref_regs[0]));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output("b2b_second_accept", 32'(busy), 32'd1);
        check_output("b2b_second_rs", 32'(rs), 32'd0);
        stray = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            stray = stray | done | rwe;
        end
        check_output("b2b_second_early", 32'(stray), 32'd0);
        @(posedge clk); #1;
        model_commit(OP_ADD, 0, 0, 2);
        check_output("b2b_second_done", 32'(done), 32'd1);
        check_output("b2b_second_dw", 32'(dw), 32'(ref_dw));
        check_flags("b2b");
        @(posedge clk); #1;
        check_output("b2b_r2", 32'(regs[2]), 32'(ref_regs[2]));

        $display("[TB] NOP and SHL");
        do_instr(OP_NOP, 1, 2, 1);
        preload(0, 4'h3);
        preload(1, 4'h3);
        do_instr(OP_SHL, 0, 1, 2);
        check_output("shl_value", 32'(regs[2]), 32'h8);

        $display("[TB] reset during MUL");
        preload(1, 4'h7);
        preload(2, 4'h5);
        check_output("abort_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = OP_MUL;
        in_rs    = 1;
        in_rt    = 2;
        in_rd    = 3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_rwe", 32'(rwe), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_ready_low", 32'(in_ready), 32'd0);
        check_output("abort_dw", 32'(dw), 32'd0);
        check_output("abort_rs", 32'(rs), 32'd0);
        stray = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            stray = stray | rwe | done;
        end
        check_output("abort_no_pulse", 32'(stray), 32'd0);
        check_output("abort_reg_unchanged", 32'(regs[3]), 32'(ref_regs[3]));
        rst_n = 1'b1;
        ref_dw = '0;
        ref_rw = '0;
        ref_zf = 1'b0;
        ref_cf = 1'b0;
        @(posedge clk); #1;
        check_output("abort_release_ready", 32'(in_ready), 32'd1);
        do_instr(OP_ADD, 1, 2, 0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                preload(2'($urandom_range(0, NREG - 1)), 4'($urandom));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, NREG - 1)),
                     2'($urandom_range(0, NREG - 1)), 2'($urandom_range(0, NREG - 1)));
        end

        for (int i = 0; i < NREG; i++) begin
            check_output("final_regfile", 32'(regs[i]), 32'(ref_regs[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Runaway guard so the bench always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
